hazard_scoreboard: RTL and testbench

Parametrised per-register hazard scoreboard for the in-order pipeline. It generalises load-use stall detection to arbitrary result latency per instruction and N source operands. It sits beside the ID stage, reserves each issued instruction's destination register for a programmable number of cycles, stalls dependent instructions, and undoes the last reservation on a branch flush. A saturating counter records total stall cycles for performance analysis.

---
 rtl/hazard_scoreboard.sv | 122 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside the ID stage.
// Reserves destinations for a set latency, stalls dependents, undoes on flush.
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int LAT_W = 3,
  parameter int N_SRC = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wb,
  input  logic [AW-1:0]         issue_rd,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [N_SRC*AW-1:0]   src_addr,
  input  logic                  flush,
  output logic                  stall,
  output logic [N_SRC-1:0]      stall_src,
  output logic [(2**AW)-1:0]    busy_vec,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int NREG = 2**AW;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  logic             last_v_q, last_v_d;
  logic [AW-1:0]    last_rd_q, last_rd_d;
  logic [LAT_W-1:0] last_prev_q, last_prev_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic             accept;
  logic             reserve;
  logic             stall_inc;
  logic [LAT_W-1:0] aged_rd;
  logic [LAT_W-1:0] undo_val;

  // Per-source hazard detection against the pre-update reservations
  always_comb begin
    stall_src = '0;
    for (int i = 0; i < N_SRC; i++) begin
      logic [AW-1:0] a;
      a = src_addr[i*AW +: AW];
      stall_src[i] = issue_valid & src_valid[i] &
                     (a != '0) & (cnt_q[a] != '0);
    end
  end

  assign stall     = |stall_src;
  assign accept    = issue_valid & ~stall & ~flush;
  assign reserve   = accept & issue_wb &
                     (issue_rd != '0) & (issue_lat != '0);
  assign stall_inc = issue_valid & stall & ~flush;

  // Squashed reservation rolls back to where the older count would be now
  assign undo_val  = (last_prev_q > LAT_W'(2)) ?
                     last_prev_q - LAT_W'(2) : '0;

  // Busy view of the reservation table
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < NREG; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  // Next-state: age all counters, then apply flush undo or new reservation
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
    end
    aged_rd     = cnt_d[issue_rd];
    last_v_d    = 1'b0;
    last_rd_d   = last_rd_q;
    last_prev_d = last_prev_q;
    if (flush) begin
      if (last_v_q) begin
        cnt_d[last_rd_q] = undo_val;
      end
    end else if (reserve) begin
      cnt_d[issue_rd] = (issue_lat > aged_rd) ? issue_lat : aged_rd;
      last_v_d        = 1'b1;
      last_rd_d       = issue_rd;
      last_prev_d     = cnt_q[issue_rd];
    end
    cnt_d[0] = '0;
  end

  // Saturating stall-cycle counter next value
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_inc && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      last_v_q       <= 1'b0;
      last_rd_q      <= '0;
      last_prev_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      last_v_q       <= last_v_d;
      last_rd_q      <= last_rd_d;
      last_prev_q    <= last_prev_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Stall counter narrowed to 4 bits so saturation is reachable.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int LAT_W = 3;
  localparam int N_SRC = 2;
  localparam int CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                issue_valid = 1'b0;
  logic                issue_wb = 1'b0;
  logic [AW-1:0]       issue_rd = '0;
  logic [LAT_W-1:0]    issue_lat = '0;
  logic [N_SRC-1:0]    src_valid = '0;
  logic [N_SRC*AW-1:0] src_addr = '0;
  logic                flush = 1'b0;
  logic                stall;
  logic [N_SRC-1:0]    stall_src;
  logic [31:0]         busy_vec;
  logic [CNT_W-1:0]    stall_cycles;

  int checks = 0;
  int passes = 0;

  hazard_scoreboard #(
    .AW(AW), .LAT_W(LAT_W), .N_SRC(N_SRC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb(issue_wb),
    .issue_rd(issue_rd), .issue_lat(issue_lat),
    .src_valid(src_valid), .src_addr(src_addr),
    .flush(flush), .stall(stall), .stall_src(stall_src),
    .busy_vec(busy_vec), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic wb,
                       input logic [AW-1:0] rd,
                       input logic [LAT_W-1:0] lat,
                       input logic [1:0] sv,
                       input logic [AW-1:0] s0,
                       input logic [AW-1:0] s1,
                       input logic fl);
    issue_valid = v;
    issue_wb    = wb;
    issue_rd    = rd;
    issue_lat   = lat;
    src_valid   = sv;
    src_addr    = {s1, s0};
    flush       = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    checks++;
    if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall);
    else passes++;
    checks++;
    if (busy_vec !== 32'h0) $display("FAIL rst_busy got %h want 0", busy_vec);
    else passes++;
    checks++;
    if (stall_cycles !== 4'd0) $display("FAIL rst_cnt got %0d want 0", stall_cycles);
    else passes++;
    rst = 1'b0;
    step();
    drive(1, 1, 3, 5, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 6, 0, 2'b01, 3, 0, 0);
    checks++;
    if (stall !== 1'b1) $display("FAIL pre_rst_stall got %b want 1", stall);
    else passes++;
    step();
    checks++;
    if (stall_cycles !== 4'd1) $display("FAIL pre_rst_cnt got %0d want 1", stall_cycles);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({stall, stall_src} !== 3'b000) $display("FAIL midrst_stall got %b want 000", {stall, stall_src});
    else passes++;
    checks++;
    if (busy_vec !== 32'h0) $display("FAIL midrst_busy got %h want 0", busy_vec);
    else passes++;
    checks++;
    if (stall_cycles !== 4'd0) $display("FAIL midrst_cnt got %0d want 0", stall_cycles);
    else passes++;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) $display("FAIL postrst_stall got %b want 0", stall);
    else passes++;
    step();
    checks++;
    if (stall_cycles !== 4'd0) $display("FAIL postrst_cnt got %0d want 0", stall_cycles);
    else passes++;
    idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 1, 5, 1, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 6, 0, 2'b01, 5, 0, 0);
    checks++;
    if (stall_src !== 2'b01) $display("FAIL lu_src got %b want 01", stall_src);
    else passes++;
    checks++;
    if (busy_vec[5] !== 1'b1) $display("FAIL lu_busy got %b want 1", busy_vec[5]);
    else passes++;
    step();
    checks++;
    if (stall !== 1'b0) $display("FAIL lu_release got %b want 0", stall);
    else passes++;
    step();
    idle();
    checks++;
    if (stall_cycles !== 4'd1) $display("FAIL lu_cnt got %0d want 1", stall_cycles);
    else passes++;
    checks++;
    if (busy_vec !== 32'h0) $display("FAIL lu_alu_busy got %h want 0", busy_vec);
    else passes++;
  endtask

  task automatic test_lat3();
    do_reset();
    drive(1, 1, 7, 3, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 8, 0, 2'b11, 7, 7, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (stall_src !== 2'b11) $display("FAIL l3_src%0d got %b want 11", k, stall_src);
      else passes++;
      step();
    end
    checks++;
    if (stall !== 1'b0) $display("FAIL l3_release got %b want 0", stall);
    else passes++;
    step();
    idle();
    checks++;
    if (stall_cycles !== 4'd3) $display("FAIL l3_cnt got %0d want 3", stall_cycles);
    else passes++;
  endtask

  task automatic test_waw();
    do_reset();
    drive(1, 1, 9, 5, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 9, 1, 2'b00, 0, 0, 0);
    checks++;
    if (stall !== 1'b0) $display("FAIL waw_nostall got %b want 0", stall);
    else passes++;
    step();
    idle();
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (busy_vec[9] !== 1'b1) $display("FAIL waw_busy_t%0d got %b want 1", k, busy_vec[9]);
      else passes++;
      step();
    end
    checks++;
    if (busy_vec[9] !== 1'b0) $display("FAIL waw_free got %b want 0", busy_vec[9]);
    else passes++;
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 1, 4, 4, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 10, 2, 2'b00, 0, 0, 1);
    step();
    idle();
    checks++;
    if (busy_vec !== 32'h0) $display("FAIL fl_squash got %h want 0", busy_vec);
    else passes++;
    drive(1, 1, 4, 2, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 11, 0, 2'b01, 4, 0, 1);
    checks++;
    if (stall !== 1'b1) $display("FAIL fl_stall got %b want 1", stall);
    else passes++;
    step();
    idle();
    checks++;
    if (stall_cycles !== 4'd0) $display("FAIL fl_cnt got %0d want 0", stall_cycles);
    else passes++;
    checks++;
    if (busy_vec[4] !== 1'b0) $display("FAIL fl_squash2 got %b want 0", busy_vec[4]);
    else passes++;
    do_reset();
    drive(1, 1, 4, 6, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 4, 4, 2'b00, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
    step();
    idle();
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (busy_vec[4] !== 1'b1) $display("FAIL fl_prior_t%0d got %b want 1", k, busy_vec[4]);
      else passes++;
      step();
    end
    checks++;
    if (busy_vec[4] !== 1'b0) $display("FAIL fl_prior_free got %b want 0", busy_vec[4]);
    else passes++;
    do_reset();
    drive(1, 1, 4, 4, 2'b00, 0, 0, 0);
    step();
    idle();
    step();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 1);
    step();
    idle();
    checks++;
    if (busy_vec[4] !== 1'b1) $display("FAIL fl_late_t3 got %b want 1", busy_vec[4]);
    else passes++;
    step();
    checks++;
    if (busy_vec[4] !== 1'b1) $display("FAIL fl_late_t4 got %b want 1", busy_vec[4]);
    else passes++;
    step();
    checks++;
    if (busy_vec[4] !== 1'b0) $display("FAIL fl_late_t5 got %b want 0", busy_vec[4]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, 1, 13, 2, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 14, 2, 2'b01, 15, 13, 0);
    checks++;
    if (stall !== 1'b0) $display("FAIL b2b_unused_src got %b want 0", stall);
    else passes++;
    step();
    checks++;
    if (busy_vec !== 32'h0000_6000) $display("FAIL b2b_busy got %h want 00006000", busy_vec);
    else passes++;
    drive(1, 1, 16, 3, 2'b01, 16, 0, 0);
    checks++;
    if (stall !== 1'b0) $display("FAIL b2b_self got %b want 0", stall);
    else passes++;
    step();
    idle();
    checks++;
    if (busy_vec !== 32'h0001_4000) $display("FAIL b2b_busy2 got %h want 00014000", busy_vec);
    else passes++;
  endtask

  task automatic sat_round();
    drive(1, 1, 12, 7, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 8, 0, 2'b10, 0, 12, 0);
    repeat (7) step();
    step();
    idle();
  endtask

  task automatic test_reg0_sat();
    do_reset();
    drive(1, 1, 0, 7, 2'b00, 0, 0, 0);
    step();
    drive(1, 1, 8, 0, 2'b01, 0, 0, 0);
    checks++;
    if (stall !== 1'b0) $display("FAIL r0_stall got %b want 0", stall);
    else passes++;
    step();
    idle();
    checks++;
    if (busy_vec !== 32'h0) $display("FAIL r0_busy got %h want 0", busy_vec);
    else passes++;
    sat_round();
    sat_round();
    checks++;
    if (stall_cycles !== 4'd14) $display("FAIL sat_mid got %0d want 14", stall_cycles);
    else passes++;
    sat_round();
    checks++;
    if (stall_cycles !== 4'd15) $display("FAIL sat_hold got %0d want 15", stall_cycles);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lat3();
    test_waw();
    test_flush();
    test_back_to_back();
    test_reg0_sat();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
